// File: rtl/firebird7_in_gate1_tessent_tdr_red_load.sv
// IJTAG redundancy-repair loader: a scan segment shifts repair entries in,
// Update-DR commits them to a small FIFO, and a drain FSM hands them to the
// repair controller over a valid/ready handshake, waiting for a done pulse.
// Capture loads a status word so progress can be polled through the same
// scan path.
module firebird7_in_gate1_tessent_tdr_red_load #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              ijtag_sel,
  input  logic              ijtag_si,
  input  logic              ijtag_ce,
  input  logic              ijtag_se,
  input  logic              ijtag_ue,
  output logic              ijtag_so,
  output logic              repair_valid,
  output logic [DATA_W-2:0] repair_addr,
  input  logic              repair_ready,
  input  logic              repair_done,
  output logic              repair_busy
);

  localparam int unsigned PTR_W = (DEPTH == 4) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] upd;
  logic [DATA_W-1:0] status;
  logic              upd_stb;
  logic [DATA_W-2:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [2:0]        occ;
  logic [2:0]        applied_cnt;
  logic              ovf_sticky;
  state_t            state;
  state_t            state_nxt;
  logic              capture;
  logic              push;
  logic              pop;
  logic              full;
  logic              push_ok;
  logic              ovf_set;

  // Segment control decode and FIFO push/overflow qualification
  always_comb begin
    capture = ijtag_ce & ijtag_sel;
    push    = upd_stb & upd[DATA_W-1];
    full    = (occ == 3'(DEPTH));
    // a pop on the same edge frees a slot, so a push into a full FIFO still lands
    push_ok = push & (~full | pop);
    ovf_set = push & full & ~pop;
  end

  // Status word; an overflow coinciding with capture must read back as set
  always_comb begin
    status      = '0;
    status[7]   = ovf_sticky | ovf_set;
    status[6]   = repair_busy;
    status[5:3] = applied_cnt;
    status[2:0] = occ;
  end

  // Capture/shift register, capture has priority over shift
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      sr <= '0;
    end else if (capture) begin
      sr <= status;
    end else if (ijtag_se && ijtag_sel) begin
      sr <= {ijtag_si, sr[DATA_W-1:1]};
    end
  end

  // Scan-out lockup latch, transparent while tck is low
  always_latch begin
    if (!ijtag_reset) begin
      ijtag_so <= 1'b0;
    end else if (!ijtag_tck) begin
      ijtag_so <= sr[0];
    end
  end

  // Update stage on the falling edge; strobe lasts until the next falling edge
  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      upd     <= '0;
      upd_stb <= 1'b0;
    end else if (ijtag_ue && ijtag_sel) begin
      upd     <= sr;
      upd_stb <= 1'b1;
    end else begin
      upd_stb <= 1'b0;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge ijtag_tck) begin
    if (push_ok) begin
      mem[wptr] <= upd[DATA_W-2:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   occ <= occ + 3'd1;
        2'b01:   occ <= occ - 3'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Sticky overflow flag, cleared by a capture unless set on the same edge
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      ovf_sticky <= 1'b0;
    end else if (ovf_set) begin
      ovf_sticky <= 1'b1;
    end else if (capture) begin
      ovf_sticky <= 1'b0;
    end
  end

  // Saturating count of entries the repair controller reported as applied
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      applied_cnt <= '0;
    end else if ((state == WAIT) && repair_done && (applied_cnt != 3'd7)) begin
      applied_cnt <= applied_cnt + 3'd1;
    end
  end

  // Drain FSM state register
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain FSM next state and handshake outputs (outputs depend on state only)
  always_comb begin
    state_nxt    = state;
    repair_valid = 1'b0;
    pop          = 1'b0;
    unique case (state)
      IDLE: begin
        if (occ != 3'd0) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        repair_valid = 1'b1;
        if (repair_ready) begin
          pop       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (repair_done) begin
          state_nxt = (occ != 3'd0) ? REQ : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    repair_busy = (state != IDLE);
    repair_addr = repair_valid ? mem[rptr] : '0;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_tdr_red_load.md
# firebird7_in_gate1_tessent_tdr_red_load

IJTAG-accessible redundancy-repair loader that delivers scanned-in repair entries to the memory repair port. A DATA_W-bit TDR segment shifts entries in. An update stage commits each entry into a DEPTH-entry FIFO. A drain FSM presents queued entries to the repair controller with a valid/ready handshake and waits for a completion pulse. Capture returns loader status, so the same scan path can be used to poll progress.

## Interface
- DATA_W, 8, TDR/entry width, ≥8; bit DATA_W-1 = entry-valid, bits DATA_W-2:0 = repair address
- DEPTH, 4, FIFO entries; legal values 2 or 4
- ijtag_tck  in  1  IJTAG clock; all state on posedge except update stage (negedge) and so latch
- ijtag_reset  in  1  reset ijtag_reset, asynchronous, active-low
- ijtag_sel  in  1  segment select
- ijtag_si  in  1  scan in
- ijtag_ce  in  1  capture enable
- ijtag_se  in  1  shift enable
- ijtag_ue  in  1  update enable
- ijtag_so  out  1  scan out
- repair_valid  out  1  entry presented
- repair_addr  out  DATA_W-1  repair address of the presented entry
- repair_ready  in  1  repair controller accepts the entry
- repair_done  in  1  one-cycle pulse: the accepted entry has been applied
- repair_busy  out  1  drain FSM not IDLE

## Operation
- Shift register sr[DATA_W-1:0], posedge:
  - ce&sel: sr <= status. Capture has priority over shift.
  - else se&sel: sr <= {si, sr[DATA_W-1:1]}.
  - else hold.
- Status word, zero-filled above bit 7:
  - [7] ovf_sticky
  - [6] repair_busy
  - [5:3] applied_cnt
  - [2:0] fifo occupancy (0..DEPTH)
- ijtag_so: level latch of sr[0], transparent while tck low.
- Update stage, negedge tck:
  - if ue&sel: upd <= sr and upd_stb <= 1.
  - else upd_stb <= 0.
- Push, posedge:
  - Occurs when upd_stb & upd[DATA_W-1]. upd_stb is seen by exactly one posedge per Update-DR.
  - Entries with valid=0 are discarded without an error.
  - Push while full (occupancy==DEPTH): entry dropped, ovf_sticky <= 1.
- ovf_sticky clear: on capture (read-to-clear). If an overflow and a capture happen on the same edge, set wins and the captured value is 1.
- FIFO:
  - circular, log2(DEPTH)-bit pointers, wrap-around.
  - push and pop on the same edge are allowed; occupancy is unchanged.
  - pop while full frees the slot for a push on the same edge, so no overflow is flagged.
- Drain FSM:
  - IDLE: if FIFO non-empty -> REQ.
  - REQ: repair_valid=1, repair_addr = FIFO head. On repair_ready, pop and -> WAIT.
  - WAIT: on repair_done, applied_cnt++ (saturates at 7), then -> REQ if FIFO non-empty, else -> IDLE.
  - repair_done outside WAIT is ignored.
  - repair_addr is stable while repair_valid=1 and ready=0.
- repair_busy = (state != IDLE), registered from state.

## Timing
- Reset values:
  - sr, upd, upd_stb, pointers, occupancy, ovf_sticky, applied_cnt all 0.
  - state IDLE.
  - repair_valid=0, repair_busy=0, repair_addr=0.
  - ijtag_so=0 after the first tck-low phase following reset.
- Reset mid-operation: the FIFO contents, the in-flight entry and the pending WAIT are abandoned. Outputs return to their reset values immediately (asynchronous).
- Latency from an Update-DR negedge:
  - entry visible in FIFO at the next posedge.
  - repair_valid high one posedge after that (IDLE->REQ).
- Handshake: transfer on a posedge with valid&ready. No combinational path from repair_ready to repair_valid.
- Minimum spacing between entries: REQ(≥1) + WAIT(≥1) = 2 cycles.

## Test plan
- Reset, then capture and shift 8 bits -> so stream 0x00. Every output at its reset value.
- Shift in 0x95, Update-DR, ready tied 1, done pulsed 3 cycles after accept:
  - repair_valid rises 2 posedges after the update negedge, repair_addr=0x15.
  - busy falls one cycle after done.
  - next capture reads 0x08 (applied_cnt=1).
- Update entry 0x15 (valid=0) -> no push, repair_valid stays 0, occupancy 0.
- ready=0, five valid updates 0x81..0x85 (DEPTH=4):
  - capture reads 0xC4 (ovf, busy, occupancy 4).
  - a second capture reads 0x44.
  - after draining, addresses are presented in order 0x01,0x02,0x03,0x04.
- Hold ready=0 with an entry presented -> repair_addr is stable. Pulse done in REQ -> ignored.
- Assert reset during WAIT -> busy/valid drop immediately. After release, a capture reads 0x00.
